// File: rtl/dmem_rr_arbiter.sv
// Two-core round-robin arbiter for a single-port data memory.
// Each transaction takes exactly three cycles: grant (IDLE edge), strobe
// (ACCESS), response capture (RESP). Every output is registered.
module dmem_rr_arbiter #(
  parameter int Ncores = 2,
  parameter int Lmem   = 8,
  parameter int TAM    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [Ncores-1:0] coreReq,
  input  logic [Ncores-1:0] coreWrite,
  input  logic [TAM-1:0]    coreADDR0,
  input  logic [TAM-1:0]    coreADDR1,
  input  logic [TAM-1:0]    coreIN0,
  input  logic [TAM-1:0]    coreIN1,
  output logic [TAM-1:0]    coreOUT0,
  output logic [TAM-1:0]    coreOUT1,
  output logic [Ncores-1:0] coreAck,
  output logic [Ncores-1:0] coreGnt,
  output logic [TAM-1:0]    memADDR,
  output logic [TAM-1:0]    memIN,
  input  logic [TAM-1:0]    memOUT,
  output logic              memWrite,
  output logic              memLoad
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t state;
  state_t stateNext;

  // Index of the most recent winner; doubles as the owner of the
  // in-flight transaction while ACCESS/RESP are active.
  logic lastGnt;
  // Latched transaction type, needed in RESP after the strobes are cleared.
  logic rdLatched;

  // Decoded control for the datapath register block.
  logic           grantEn;
  logic           winner;
  logic [TAM-1:0] selAddr;
  logic [TAM-1:0] selIn;
  logic           selWrite;

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // Next-state logic: fixed IDLE -> ACCESS -> RESP -> IDLE walk.
  // NOTE: the default assignment first keeps this block free of latches.
  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (coreReq != '0) stateNext = ACCESS;
      ACCESS:  stateNext = RESP;
      RESP:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Output decode: winner selection and operand muxing for the grant edge.
  always_comb begin
    grantEn  = (state == IDLE) && (coreReq != '0);
    // On a tie the core that did not win last time goes next.
    if (coreReq[0] && coreReq[1]) begin
      winner = ~lastGnt;
    end else begin
      winner = coreReq[1];
    end
    selAddr  = winner ? coreADDR1 : coreADDR0;
    selIn    = winner ? coreIN1   : coreIN0;
    selWrite = coreWrite[winner];
  end

  // Registered outputs: grant latch, strobe drop, response capture and ack.
  // NOTE: every flop here has a reset value; there is no storage array in
  // this block, so nothing is left uninitialised after reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      coreOUT0  <= '0;
      coreOUT1  <= '0;
      coreAck   <= '0;
      coreGnt   <= '0;
      memADDR   <= '0;
      memIN     <= '0;
      memWrite  <= 1'b0;
      memLoad   <= 1'b0;
      lastGnt   <= 1'b1;
      rdLatched <= 1'b0;
    end else begin
      // Ack is a single-cycle pulse.
      coreAck <= '0;

      if (grantEn) begin
        coreGnt   <= winner ? Ncores'(2) : Ncores'(1);
        lastGnt   <= winner;
        memADDR   <= {{(TAM-Lmem){1'b0}}, selAddr[Lmem-1:0]};
        memIN     <= selIn;
        memWrite  <= selWrite;
        memLoad   <= ~selWrite;
        rdLatched <= ~selWrite;
      end

      if (state == ACCESS) begin
        memWrite <= 1'b0;
        memLoad  <= 1'b0;
      end

      if (state == RESP) begin
        if (rdLatched) begin
          if (lastGnt) begin
            coreOUT1 <= memOUT;
          end else begin
            coreOUT0 <= memOUT;
          end
        end
        coreAck <= lastGnt ? Ncores'(2) : Ncores'(1);
        coreGnt <= '0;
      end
    end
  end

endmodule
